// File: rtl/datapath_wall_pkg.sv
// Shared definitions for the wall datapath: FSM state encoding, colour constants, gap clamp.
// Also used by the bird datapath, so keep it free of module-specific parameters.
package datapath_wall_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERASE  = 3'd1,
    S_UPDATE = 3'd2,
    S_DRAW   = 3'd3,
    S_CHECK  = 3'd4
  } state_t;

  localparam int DEFAULT_SCREEN_W = 160;
  localparam int DEFAULT_SCREEN_H = 120;
  localparam logic [2:0] COLOUR_ERASE = 3'b000;
  localparam logic [2:0] COLOUR_WALL  = 3'b010;

  // Keeps the whole opening on screen: gap top never exceeds SCREEN_H-GAP_H.
  function automatic logic [6:0] clamp_gap(input logic [6:0] g, input logic [6:0] limit);
    return (g > limit) ? limit : g;
  endfunction

endpackage

// File: rtl/datapath_wall_rate_divider.sv
// Frame tick generator: counts enabled clocks and pulses tick on count DIV-1, then wraps.
module rate_divider #(
  parameter int DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  assign tick = enable && (count == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/datapath_wall.sv
// Wall datapath: holds wall position/gap, erases and redraws it one pixel per clock, flags collisions.
// Optional WALL_SCORE_EN adds an 8-bit saturating score counted on each wall wrap.
module datapath_wall
  import datapath_wall_pkg::*;
#(
  parameter int         SCREEN_W    = DEFAULT_SCREEN_W,
  parameter int         SCREEN_H    = DEFAULT_SCREEN_H,
  parameter int         WALL_W      = 4,
  parameter int         GAP_H       = 30,
  parameter int         STEP        = 1,
  parameter int         FRAME_DIV   = 833333,
  parameter logic [2:0] WALL_COLOUR = COLOUR_WALL
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       move,
  input  logic [6:0] gap_y,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       touched
`ifdef WALL_SCORE_EN
  ,
  output logic [7:0] score
`endif
);

  localparam logic [7:0] WALL_X0  = 8'(SCREEN_W - WALL_W);
  localparam logic [6:0] GAP_MAX  = 7'(SCREEN_H - GAP_H);
  localparam logic [7:0] COL_LAST = 8'(WALL_W - 1);
  localparam logic [6:0] ROW_LAST = 7'(SCREEN_H - 1);
  localparam logic [7:0] STEP_V   = 8'(STEP);

  state_t     state, state_next;
  logic [7:0] wall_x;
  logic [6:0] gap;
  logic [7:0] col;
  logic [6:0] row;
  logic       tick;
  logic       div_resetn;
  logic       scan_last;
  logic       wrap;
  logic [8:0] wall_end;
  logic [7:0] gap_end;
  logic       row_solid;
  logic       hit;

  // start restarts the frame count as well, so a fresh wall waits a full frame.
  assign div_resetn = resetn && !start;

  rate_divider #(.DIV(FRAME_DIV)) u_frame (
    .clk    (clk),
    .resetn (div_resetn),
    .enable (move),
    .tick   (tick)
  );

  assign scan_last = (col == COL_LAST) && (row == ROW_LAST);
  assign wrap      = (wall_x < STEP_V);
  assign wall_end  = {1'b0, wall_x} + 9'(WALL_W);
  assign gap_end   = {1'b0, gap} + 8'(GAP_H);
  assign row_solid = (row < gap) || ({1'b0, row} >= gap_end);
  assign hit       = (player_x >= wall_x) && ({1'b0, player_x} < wall_end) &&
                     ((player_y < gap) || ({1'b0, player_y} >= gap_end));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (tick && move) state_next = S_ERASE;
      S_ERASE:  if (scan_last) state_next = S_UPDATE;
      S_UPDATE: state_next = S_DRAW;
      S_DRAW:   if (scan_last) state_next = S_CHECK;
      S_CHECK:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Pixel outputs trail the scan counters by one clock; touched is timed to coincide with CHECK.
  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      state   <= S_IDLE;
      wall_x  <= WALL_X0;
      gap     <= resetn ? clamp_gap(gap_y, GAP_MAX) : 7'd0;
      col     <= '0;
      row     <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= COLOUR_ERASE;
      plot    <= 1'b0;
      touched <= 1'b0;
    end else begin
      state   <= state_next;
      plot    <= 1'b0;
      touched <= 1'b0;
      case (state)
        S_ERASE, S_DRAW: begin
          x      <= wall_x + col;
          y      <= row;
          colour <= (state == S_DRAW) ? WALL_COLOUR : COLOUR_ERASE;
          plot   <= (state == S_ERASE) || row_solid;
          if (row == ROW_LAST) begin
            row <= '0;
            col <= scan_last ? 8'd0 : col + 8'd1;
          end else begin
            row <= row + 7'd1;
          end
          if (state == S_DRAW && scan_last) touched <= hit;
        end
        S_UPDATE: begin
          if (wrap) begin
            wall_x <= WALL_X0;
            gap    <= clamp_gap(gap_y, GAP_MAX);
          end else begin
            wall_x <= wall_x - STEP_V;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WALL_SCORE_EN
  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      score <= '0;
    end else if (state == S_UPDATE && wrap && score != 8'hFF) begin
      score <= score + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_datapath_wall.sv
// Randomised self-checking bench for datapath_wall on a 16x8 screen with a frame-level reference model.
// Each frame's erase/draw pixel sets and touched pulse are compared against the model.
module tb_datapath_wall;

  localparam int SW = 16;
  localparam int SH = 8;
  localparam int WW = 2;
  localparam int GH = 3;
  localparam int FD = 40;
  localparam logic [2:0] WALLC = 3'b010;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       move = 1'b0;
  logic [6:0] gap_y = '0;
  logic [7:0] player_x = '0;
  logic [6:0] player_y = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       touched;
`ifdef WALL_SCORE_EN
  logic [7:0] score;
`endif

  datapath_wall #(
    .SCREEN_W(SW), .SCREEN_H(SH), .WALL_W(WW), .GAP_H(GH),
    .STEP(1), .FRAME_DIV(FD), .WALL_COLOUR(WALLC)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .move(move), .gap_y(gap_y),
    .player_x(player_x), .player_y(player_y),
    .x(x), .y(y), .colour(colour), .plot(plot), .touched(touched)
`ifdef WALL_SCORE_EN
    , .score(score)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t rec[$];
  int   touch_cnt = 0;
  int   checks = 0;
  int   passes = 0;

  // Reference model: wall column, gap top, wrap count
  int m_wall = SW - WW;
  int m_gap = 0;
  int m_wraps = 0;

  always @(negedge clk) begin
    if (plot) rec.push_back('{int'(x), int'(y), int'(colour)});
    if (touched) touch_cnt++;
  end

  function automatic int clampg(input int g);
    return (g > SH - GH) ? SH - GH : g;
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic applyStart(input int g);
    @(posedge clk); #1;
    start = 1'b1;
    gap_y = 7'(g);
    @(posedge clk); #1;
    start = 1'b0;
    m_wall = SW - WW;
    m_gap = clampg(g);
  endtask

  // One frame: move high for exactly one frame period, then dropped mid-ERASE.
  task automatic applyStimulus(input int g, input int px, input int py, input string tag);
    int  ow, nw, eerr, derr, ndraw, exp_touch;
    bit  seen_e[SW][SH];
    bit  seen_d[SW][SH];
    @(posedge clk); #1;
    gap_y = 7'(g);
    player_x = 8'(px);
    player_y = 7'(py);
    rec.delete();
    touch_cnt = 0;
    move = 1'b1;
    repeat (FD) @(posedge clk);
    #1 move = 1'b0;
    repeat (FD + 5) @(posedge clk);

    ow = m_wall;
    if (m_wall < 1) begin
      m_wall = SW - WW;
      m_gap = clampg(g);
      m_wraps++;
    end else begin
      m_wall = m_wall - 1;
    end
    nw = m_wall;
    ndraw = 0;
    for (int r = 0; r < SH; r++) if (r < m_gap || r >= m_gap + GH) ndraw += WW;
    exp_touch = (px >= nw && px < nw + WW && (py < m_gap || py >= m_gap + GH)) ? 1 : 0;

    eerr = 0;
    derr = 0;
    for (int i = 0; i < rec.size(); i++) begin
      pix_t p = rec[i];
      if (p.x >= SW || p.y >= SH) begin
        if (i < SH * WW) eerr++; else derr++;
        continue;
      end
      if (i < SH * WW) begin
        if (p.c != 0 || p.x < ow || p.x >= ow + WW || seen_e[p.x][p.y]) eerr++;
        seen_e[p.x][p.y] = 1'b1;
      end else begin
        if (p.c != int'(WALLC) || p.x < nw || p.x >= nw + WW ||
            (p.y >= m_gap && p.y < m_gap + GH) || seen_d[p.x][p.y]) derr++;
        seen_d[p.x][p.y] = 1'b1;
      end
    end
    checkOutput({tag, "_plots"}, rec.size(), SH * WW + ndraw);
    checkOutput({tag, "_erase_bad"}, eerr, 0);
    checkOutput({tag, "_draw_bad"}, derr, 0);
    checkOutput({tag, "_touched"}, touch_cnt, exp_touch);
  endtask

  initial begin
    bit found;

    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_plot", int'(plot), 0);
    checkOutput("rst_touched", int'(touched), 0);
    checkOutput("rst_x", int'(x), 0);
    checkOutput("rst_y", int'(y), 0);
    checkOutput("rst_colour", int'(colour), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    m_wall = SW - WW;
    m_gap = 0;

    // Reset gap 0 first frame, then directed loads
    applyStimulus(0, 0, 7, "reset_frame");
    applyStart(2);
    applyStimulus(2, 0, 0, "gap2");
    applyStart(7);
    applyStimulus(7, 0, 0, "gap7_clamped");
    applyStart(2);
    applyStimulus(2, 13, 0, "hit_top");
    applyStimulus(2, 13, 3, "in_gap");

    // Random frames walking the wall through a wrap
    for (int f = 0; f < 16; f++)
      applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, SW - 1)),
                    int'($urandom_range(0, SH - 1)), $sformatf("rand%0d", f));

    // start during DRAW aborts the sequence and reloads the wall
    @(posedge clk); #1;
    move = 1'b1;
    repeat (FD) @(posedge clk);
    #1 move = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3 * FD && !found; i++) begin
      @(negedge clk);
      if (plot && colour == WALLC) found = 1'b1;
    end
    checkOutput("draw_reached", int'(found), 1);
    @(posedge clk); #1;
    start = 1'b1;
    gap_y = 7'd3;
    @(posedge clk); #1;
    start = 1'b0;
    m_wall = SW - WW;
    m_gap = 3;
    @(negedge clk);
    checkOutput("abort_plot", int'(plot), 0);
    checkOutput("abort_touched", int'(touched), 0);
    rec.delete();
    repeat (FD + 5) @(posedge clk);
    checkOutput("abort_idle_plots", rec.size(), 0);
    applyStimulus(3, 14, 7, "after_abort");

    // With move low no further frames are drawn
    rec.delete();
    repeat (3 * FD) @(posedge clk);
    checkOutput("no_tick_plots", rec.size(), 0);

`ifdef WALL_SCORE_EN
    checkOutput("score", int'(score), m_wraps);
`endif

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
